// File: rtl/imem_arbiter.sv
// Shares one synchronous-read word memory between instruction fetch and the
// load/store port; data wins ties unless fetch has been denied STARVE_MAX times.
module imem_arbiter #(
  parameter int IDX_W      = 15,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [3:0]       d_wstrb,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             mem_en,
  output logic [3:0]       mem_we,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       starve_hit;
  logic       if_rd_q;
  logic       d_rd_q;

  assign starve_hit = (starve_cnt == STARVE_LIM);

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (if_req && d_req) begin
        if_gnt = starve_hit;
        d_gnt  = !starve_hit;
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end
  end

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = '0;
    mem_idx   = d_addr[IDX_W+1:2];
    mem_wdata = d_wdata;
    if (if_gnt) begin
      mem_idx = if_addr[IDX_W+1:2];
    end else if (d_gnt && d_we) begin
      mem_we = d_wstrb;
    end
  end

  // Counter saturates at the limit so a long denial run never wraps past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_gnt || !if_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_rd_q <= 1'b0;
      d_rd_q  <= 1'b0;
    end else begin
      if_rd_q <= if_gnt;
      d_rd_q  <= d_gnt && !d_we;
    end
  end

  assign if_rvalid = if_rd_q;
  assign d_rvalid  = d_rd_q;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:IDX_W+2], if_addr[1:0],
                              d_addr[31:IDX_W+2], d_addr[1:0]};

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomised and directed bench for imem_arbiter against a behavioural model
// of arbitration, memory contents and response timing.
module tb_imem_arbiter;
  localparam int IDX_W = 15;
  localparam int SM    = 4;
  localparam int DEPTH = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  imem_arbiter #(.IDX_W(IDX_W), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory macro: single port, synchronous read, byte-masked write.
  logic [31:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0) begin
        mem_rdata <= mem[mem_idx];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:DEPTH-1];
  int          denied_run = 0;
  logic        exp_if_rv = 1'b0, exp_d_rv = 1'b0;
  logic [31:0] exp_if_data = '0, exp_d_data = '0;
  logic        last_if_g = 1'b0, last_d_g = 1'b0;

  logic        obs_if_gnt, obs_d_gnt, obs_mem_en, obs_if_rv, obs_d_rv;
  logic [3:0]  obs_mem_we;
  logic [31:0] obs_mem_idx, obs_if_rdata, obs_d_rdata;

  int checks = 0;
  int failures = 0;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // One cycle: compare at negedge+1, then advance the model on the rising edge.
  task automatic tick();
    logic e_if, e_d, e_en;
    logic [3:0] e_we;
    int e_idx;
    #1;
    e_if = 1'b0; e_d = 1'b0;
    if (!rst) begin
      if (if_req && d_req) begin
        if (denied_run >= SM) e_if = 1'b1; else e_d = 1'b1;
      end else begin
        e_if = if_req;
        e_d  = d_req;
      end
    end
    e_en  = e_if | e_d;
    e_we  = (e_d && d_we) ? d_wstrb : 4'b0;
    e_idx = e_if ? idx_of(if_addr) : idx_of(d_addr);

    obs_if_gnt = if_gnt; obs_d_gnt = d_gnt; obs_mem_en = mem_en;
    obs_mem_we = mem_we; obs_mem_idx = 32'(mem_idx);
    obs_if_rv = if_rvalid; obs_d_rv = d_rvalid;
    obs_if_rdata = if_rdata; obs_d_rdata = d_rdata;

    chk("if_gnt", 32'(if_gnt), 32'(e_if));
    chk("d_gnt", 32'(d_gnt), 32'(e_d));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_en) chk("mem_idx", 32'(mem_idx), 32'(e_idx));
    if (e_d && d_we) chk("mem_wdata", mem_wdata, d_wdata);
    chk("if_rvalid", 32'(if_rvalid), 32'(exp_if_rv));
    if (exp_if_rv) chk("if_rdata", if_rdata, exp_if_data);
    chk("d_rvalid", 32'(d_rvalid), 32'(exp_d_rv));
    if (exp_d_rv) chk("d_rdata", d_rdata, exp_d_data);
    chk("rvalid_excl", 32'(if_rvalid & d_rvalid), 32'd0);
    last_if_g = e_if;
    last_d_g  = e_d;

    @(posedge clk);
    if (rst) begin
      denied_run = 0;
      exp_if_rv  = 1'b0;
      exp_d_rv   = 1'b0;
    end else begin
      exp_if_rv = e_if;
      exp_d_rv  = e_d && !d_we;
      if (e_if) exp_if_data = ref_mem[idx_of(if_addr)];
      if (e_d && !d_we) exp_d_data = ref_mem[idx_of(d_addr)];
      if (e_d && d_we)
        for (int b = 0; b < 4; b++)
          if (d_wstrb[b]) ref_mem[idx_of(d_addr)][8*b +: 8] = d_wdata[8*b +: 8];
      if (if_req && !e_if) denied_run++; else denied_run = 0;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) a = a | ($urandom << (IDX_W + 2));
    return a;
  endfunction

  task automatic idle();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] <= '0;
      ref_mem[i] = '0;
    end
    mem[16] <= 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    mem[64] <= 32'h11223344; ref_mem[64] = 32'h11223344;

    @(posedge clk);
    @(negedge clk);

    // Reset with both requesting
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_gnt", 32'({obs_if_gnt, obs_d_gnt, obs_mem_en}), 32'd0);
      chk("rst_no_rvalid", 32'({obs_if_rv, obs_d_rv}), 32'd0);
    end
    rst = 1'b0;
    tick();
    chk("release_d_first", 32'({obs_if_gnt, obs_d_gnt}), 32'b01);
    idle(); tick();

    // Fetch only
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    chk("fetch_gnt", 32'(obs_if_gnt), 32'd1);
    chk("fetch_idx", obs_mem_idx, 32'h10);
    idle(); tick();
    chk("fetch_rvalid", 32'(obs_if_rv), 32'd1);
    chk("fetch_rdata", obs_if_rdata, 32'hDEADBEEF);

    // Byte write then read-back
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wstrb = 4'b0010; d_wdata = 32'h0000AB00;
    tick();
    chk("wr_gnt", 32'(obs_d_gnt), 32'd1);
    chk("wr_mem_we", 32'(obs_mem_we), 32'h2);
    d_we = 1'b0;
    tick();
    chk("wr_no_rvalid", 32'(obs_d_rv), 32'd0);
    idle(); tick();
    chk("rd_rvalid", 32'(obs_d_rv), 32'd1);
    chk("rd_merged", obs_d_rdata, 32'h1122AB44);
    tick();
    chk("rd_rvalid_once", 32'(obs_d_rv), 32'd0);

    // Starvation limit
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int c = 1; c <= SM + 2; c++) begin
      tick();
      chk("starve_gnt", 32'({obs_if_gnt, obs_d_gnt}), (c == SM + 1) ? 32'b10 : 32'b01);
    end
    idle(); tick();

    // Address wrap
    if_req = 1'b1; if_addr = 32'h0002_0004;
    tick();
    chk("wrap_hi", obs_mem_idx, 32'h1);
    if_addr = 32'h43;
    tick();
    chk("wrap_lo", obs_mem_idx, 32'h10);
    idle(); tick();

    // Reset mid-stream
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    tick();
    chk("ms_gnt", 32'(obs_d_gnt), 32'd1);
    rst = 1'b1;
    tick();
    chk("ms_rvalid", 32'(obs_d_rv), 32'd1);
    chk("ms_rdata", obs_d_rdata, 32'h1122AB44);
    chk("ms_no_gnt", 32'(obs_d_gnt), 32'd0);
    tick();
    chk("ms_rvalid_clr", 32'(obs_d_rv), 32'd0);
    rst = 1'b0; idle(); tick();

    // Randomised traffic with hold-until-granted requesters
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!if_req || last_if_g) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = rand_addr();
      end
      if (!d_req || last_d_g) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = ($urandom_range(0, 2) == 0);
        d_wstrb = 4'($urandom_range(0, 15));
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end
      tick();
    end
    rst = 1'b0; idle(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter that shares one single-port, synchronous-read 128 KB word memory between the core's instruction-fetch port and its load/store data port. Sits between the fetch/LSU logic and the memory macro. Each cycle it grants at most one requester, issues the access, and returns read data one cycle later. Data accesses have priority, bounded by an anti-starvation counter for fetch.

## Interface
Parameters:
- IDX_W, 15, word-index width (2^15 words = 128 KB)
- STARVE_MAX, 4, consecutive fetch denials after which fetch wins; legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid this cycle
- if_rdata  out  32  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_wstrb  in  4  byte write enables, bit i = byte i
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid this cycle (reads only)
- d_rdata  out  32  data read data
- mem_en  out  1  memory access enable
- mem_we  out  4  memory byte write enables
- mem_idx  out  IDX_W  memory word index
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid cycle after mem_en with mem_we = 0

## Operation
- Handshake: transfer occurs when req && gnt in the same cycle. Requester holds req/addr/wdata stable until granted. gnt is combinational from req, starve counter and rst.
- Arbitration per cycle:
  - rst = 1: if_gnt = d_gnt = 0.
  - only one req: that requester granted.
  - both: d_gnt = 1 unless starve_cnt == STARVE_MAX, then if_gnt = 1.
- starve_cnt (4 bits): reset 0; increments (saturating at STARVE_MAX) each cycle if_req && !if_gnt; cleared to 0 when if_gnt or !if_req.
- Memory drive (combinational): mem_en = if_gnt | d_gnt. mem_idx = granted addr[IDX_W+1:2]; addr[1:0] and addr[31:IDX_W+2] ignored (wrap). Fetch: mem_we = 0. Data: mem_we = d_we ? d_wstrb : 4'b0; mem_wdata = d_wdata. Data write with d_wstrb = 0 is a granted no-op access. When idle, mem_en = 0, mem_we = 0, mem_idx/mem_wdata don't-care.
- Response: registers if_rd_q, d_rd_q. Next cycle if_rvalid = if_rd_q (set by if_gnt), d_rvalid = d_rd_q (set by d_gnt && !d_we). if_rdata = d_rdata = mem_rdata, meaningful only with matching rvalid.
- Writes produce no response; write completion is the grant.
- Read-after-write to same index in consecutive cycles returns new data (memory ordering by cycle).

## Timing
- Reset values: if_rvalid = 0, d_rvalid = 0, starve_cnt = 0; gnt outputs and mem_en = 0 during rst.
- Latency: grant at cycle N → rvalid at N+1. Throughput: one access per cycle, back-to-back grants allowed.
- rst asserted at cycle N with a read granted at N-1: read granted at N-1 still returns rvalid at N? No — rvalid registers clear at reset, so rvalid is 0 at N+1 and no request is granted at N; the in-flight read issued at N-1 still produces its rvalid at N (registered before reset edge).
- Simultaneous if_rvalid and d_rvalid never occur.
- Fetch worst-case wait under continuous data traffic: STARVE_MAX cycles, granted on cycle STARVE_MAX+1.

## Test plan
- Reset: hold rst 3 cycles with both reqs high → no gnt, mem_en = 0, rvalid = 0; release → d_gnt first cycle.
- Fetch only: preload mem[0x10] = 0xDEADBEEF, if_addr = 0x40 → if_gnt cycle N, if_rvalid and if_rdata = 0xDEADBEEF at N+1.
- Byte write then read: d_addr = 0x100, wstrb = 4'b0010, wdata = 0x0000AB00 over word 0x11223344 → next cycle read returns 0x1122AB44, d_rvalid once, no rvalid for the write.
- Starvation: both req held high, STARVE_MAX = 4 → d_gnt cycles 1–4, if_gnt cycle 5, counter back to 0, d_gnt cycle 6.
- Address wrap: if_addr = 0x0002_0004 → mem_idx = 1; if_addr = 0x43 → mem_idx = 0x10.
- Reset mid-stream: data read granted cycle N, rst at N+1 → d_rvalid at N+1, nothing at N+2, no grants while rst high.
